// File: rtl/rob_commit.sv
// rob_commit: in-order retirement buffer that feeds the register-file write port.
//
// Dispatch allocates entries in program order and receives the tail pointer
// as its tag. Execution units complete entries by tag, in any order. The head
// entry retires when it is done, at most one entry per cycle, and drives the
// register-file write port. flush_i discards every entry in flight.
//
// Ports
//   clk_i, rst_ni             clock (rising edge), async active-low reset
//   alloc_valid_i/alloc_rd_i  dispatch request and its destination register
//   alloc_ready_o/alloc_tag_o buffer not full / tag granted (tail pointer)
//   cmpl_valid_i/_tag_i/_data_i  execution result for an entry
//   flush_i                   synchronous squash of all entries
//   commit_o                  head entry retires this cycle
//   rf_wr_en_o/_addr_o/_data_o   register-file write port (rd=0 never writes)
//   count_o, empty_o          occupancy
//
// Per-entry state
//   state   | meaning
//   FREE    | slot unused
//   PENDING | allocated, waiting for its result
//   DONE    | result captured, waiting to retire from the head
module rob_commit #(
    parameter int  DEPTH = 8,
    parameter int  XLEN  = 32,
    localparam int TAG_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             alloc_valid_i,
    input  logic [4:0]       alloc_rd_i,
    output logic             alloc_ready_o,
    output logic [TAG_W-1:0] alloc_tag_o,
    input  logic             cmpl_valid_i,
    input  logic [TAG_W-1:0] cmpl_tag_i,
    input  logic [XLEN-1:0]  cmpl_data_i,
    input  logic             flush_i,
    output logic             commit_o,
    output logic             rf_wr_en_o,
    output logic [4:0]       rf_wr_addr_o,
    output logic [XLEN-1:0]  rf_wr_data_o,
    output logic [TAG_W:0]   count_o,
    output logic             empty_o
);

    localparam logic [1:0] ST_FREE    = 2'b00;
    localparam logic [1:0] ST_PENDING = 2'b01;
    localparam logic [1:0] ST_DONE    = 2'b10;

    localparam logic [TAG_W-1:0] TAG_ONE = TAG_W'(1);
    localparam logic [TAG_W:0]   CNT_ONE = (TAG_W + 1)'(1);
    localparam logic [TAG_W:0]   CNT_MAX = (TAG_W + 1)'(DEPTH);

    logic [1:0]       state_q [DEPTH];
    logic [4:0]       rd_q    [DEPTH];
    logic [XLEN-1:0]  data_q  [DEPTH];
    logic [TAG_W-1:0] head_q;
    logic [TAG_W-1:0] tail_q;
    logic [TAG_W:0]   count_q;

    logic head_valid;
    logic head_done;
    logic alloc_fire;
    logic cmpl_hit;

    assign head_valid = (state_q[head_q] != ST_FREE);
    assign head_done  = (state_q[head_q] == ST_DONE);

    // Readiness looks only at the registered count, so a retirement in the
    // same cycle never opens a slot for allocation until the next cycle.
    assign alloc_ready_o = (count_q != CNT_MAX);
    assign alloc_tag_o   = tail_q;
    assign alloc_fire    = alloc_valid_i & alloc_ready_o & ~flush_i;

    // Only a PENDING entry accepts a result: late results to free slots and
    // duplicate results to finished entries are dropped (first result wins).
    assign cmpl_hit = cmpl_valid_i & (state_q[cmpl_tag_i] == ST_PENDING) & ~flush_i;

    assign commit_o     = head_done & ~flush_i;
    assign rf_wr_en_o   = commit_o & (rd_q[head_q] != 5'd0);
    assign rf_wr_addr_o = head_valid ? rd_q[head_q]   : 5'd0;
    assign rf_wr_data_o = head_valid ? data_q[head_q] : '0;

    assign count_o = count_q;
    assign empty_o = (count_q == '0);

    // The alloc, completion and commit writes below can never hit the same
    // slot in one cycle: they target FREE, PENDING and DONE entries
    // respectively.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                state_q[i] <= ST_FREE;
                rd_q[i]    <= 5'd0;
                data_q[i]  <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                state_q[i] <= ST_FREE;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (alloc_fire) begin
                state_q[tail_q] <= ST_PENDING;
                rd_q[tail_q]    <= alloc_rd_i;
                tail_q          <= tail_q + TAG_ONE;
            end
            if (cmpl_hit) begin
                state_q[cmpl_tag_i] <= ST_DONE;
                data_q[cmpl_tag_i]  <= cmpl_data_i;
            end
            if (commit_o) begin
                state_q[head_q] <= ST_FREE;
                head_q          <= head_q + TAG_ONE;
            end
            case ({alloc_fire, commit_o})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_rob_commit.sv
module tb_rob_commit;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        alloc_valid_i;
    logic [4:0]  alloc_rd_i;
    logic        alloc_ready_o;
    logic [2:0]  alloc_tag_o;
    logic        cmpl_valid_i;
    logic [2:0]  cmpl_tag_i;
    logic [31:0] cmpl_data_i;
    logic        flush_i;
    logic        commit_o;
    logic        rf_wr_en_o;
    logic [4:0]  rf_wr_addr_o;
    logic [31:0] rf_wr_data_o;
    logic [3:0]  count_o;
    logic        empty_o;

    rob_commit dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .alloc_valid_i (alloc_valid_i),
        .alloc_rd_i    (alloc_rd_i),
        .alloc_ready_o (alloc_ready_o),
        .alloc_tag_o   (alloc_tag_o),
        .cmpl_valid_i  (cmpl_valid_i),
        .cmpl_tag_i    (cmpl_tag_i),
        .cmpl_data_i   (cmpl_data_i),
        .flush_i       (flush_i),
        .commit_o      (commit_o),
        .rf_wr_en_o    (rf_wr_en_o),
        .rf_wr_addr_o  (rf_wr_addr_o),
        .rf_wr_data_o  (rf_wr_data_o),
        .count_o       (count_o),
        .empty_o       (empty_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [4:0] rd;
        logic [2:0] tag;
    } sb_t;

    sb_t         sb [$];
    logic [31:0] exp_data [8];
    int          passed = 0;
    int          total  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic idle();
        alloc_valid_i = 1'b0;
        alloc_rd_i    = 5'd0;
        cmpl_valid_i  = 1'b0;
        cmpl_tag_i    = 3'd0;
        cmpl_data_i   = 32'd0;
        flush_i       = 1'b0;
    endtask

    task automatic cmpl(input logic [2:0] tag, input logic [31:0] data);
        cmpl_valid_i = 1'b1;
        cmpl_tag_i   = tag;
        cmpl_data_i  = data;
    endtask

    // Checks the current cycle with inputs already driven, then advances one
    // clock and returns the inputs to idle. Retirements pop the scoreboard.
    task automatic cyc(input logic exp_commit);
        sb_t e;
        #1;
        chk("commit", commit_o, exp_commit);
        if (commit_o === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("wr_addr", rf_wr_addr_o, e.rd);
                chk("wr_data", rf_wr_data_o, exp_data[e.tag]);
                chk("wr_en", rf_wr_en_o, e.rd != 5'd0);
            end
        end
        @(posedge clk_i);
        #1;
        idle();
    endtask

    task automatic alloc_cyc(input logic [4:0] rd, input logic [2:0] exp_tag, input logic exp_commit);
        sb_t e;
        alloc_valid_i = 1'b1;
        alloc_rd_i    = rd;
        #1;
        chk("alloc_ready", alloc_ready_o, 1'b1);
        chk("alloc_tag", alloc_tag_o, exp_tag);
        e.rd  = rd;
        e.tag = exp_tag;
        sb.push_back(e);
        cyc(exp_commit);
    endtask

    initial begin
        rst_ni = 1'b0;
        idle();
        for (int i = 0; i < 8; i++) exp_data[i] = 32'd0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_ready", alloc_ready_o, 1'b1);
        chk("rst_tag", alloc_tag_o, 3'd0);
        chk("rst_commit", commit_o, 1'b0);
        chk("rst_wr_en", rf_wr_en_o, 1'b0);
        chk("rst_wr_addr", rf_wr_addr_o, 5'd0);
        chk("rst_wr_data", rf_wr_data_o, 32'd0);
        chk("rst_count", count_o, 4'd0);
        chk("rst_empty", empty_o, 1'b1);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // In-order completion
        alloc_cyc(5'd5, 3'd0, 1'b0);
        alloc_cyc(5'd6, 3'd1, 1'b0);
        cmpl(3'd0, 32'h11); exp_data[0] = 32'h11; cyc(1'b0);
        cmpl(3'd1, 32'h22); exp_data[1] = 32'h22; cyc(1'b1);
        cyc(1'b1);
        cyc(1'b0);
        chk("t2_empty", empty_o, 1'b1);

        // Out-of-order completion: nothing retires until the oldest is done
        alloc_cyc(5'd1, 3'd2, 1'b0);
        alloc_cyc(5'd2, 3'd3, 1'b0);
        alloc_cyc(5'd3, 3'd4, 1'b0);
        cmpl(3'd4, 32'hC0); exp_data[4] = 32'hC0; cyc(1'b0);
        cmpl(3'd3, 32'hB0); exp_data[3] = 32'hB0; cyc(1'b0);
        cmpl(3'd2, 32'hA0); exp_data[2] = 32'hA0; cyc(1'b0);
        cyc(1'b1);
        cyc(1'b1);
        cyc(1'b1);
        cyc(1'b0);
        chk("t3_count", count_o, 4'd0);

        // Async reset in the middle of a retirement
        alloc_cyc(5'd7, 3'd5, 1'b0);
        cmpl(3'd5, 32'h77); exp_data[5] = 32'h77; cyc(1'b0);
        #1;
        chk("pre_rst_wr_en", rf_wr_en_o, 1'b1);
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_count", count_o, 4'd0);
        chk("mid_rst_empty", empty_o, 1'b1);
        chk("mid_rst_wr_en", rf_wr_en_o, 1'b0);
        chk("mid_rst_tag", alloc_tag_o, 3'd0);
        chk("mid_rst_commit", commit_o, 1'b0);
        sb.delete();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Fill, full-with-commit, wrap
        for (int k = 0; k < 8; k++) alloc_cyc(5'(8 + k), 3'(k), 1'b0);
        #1;
        chk("full_ready", alloc_ready_o, 1'b0);
        chk("full_count", count_o, 4'd8);
        cmpl(3'd0, 32'h100); exp_data[0] = 32'h100; cyc(1'b0);
        alloc_valid_i = 1'b1;
        alloc_rd_i    = 5'd20;
        #1;
        chk("full_commit_ready", alloc_ready_o, 1'b0);
        cyc(1'b1);
        chk("after_commit_count", count_o, 4'd7);
        alloc_cyc(5'd21, 3'd0, 1'b0);
        chk("refill_count", count_o, 4'd8);
        for (int k = 1; k < 8; k++) begin
            cmpl(3'(k), 32'h100 + 32'(k));
            exp_data[k] = 32'h100 + 32'(k);
            cyc(k > 1);
        end
        cmpl(3'd0, 32'h200); exp_data[0] = 32'h200; cyc(1'b1);
        cyc(1'b1);
        cyc(1'b0);
        chk("t4_empty", empty_o, 1'b1);

        // rd=0 retires without a write; duplicate completion is dropped
        alloc_cyc(5'd0, 3'd1, 1'b0);
        alloc_cyc(5'd9, 3'd2, 1'b0);
        cmpl(3'd2, 32'h55); exp_data[2] = 32'h55; cyc(1'b0);
        cmpl(3'd2, 32'h99); cyc(1'b0);
        cmpl(3'd1, 32'h33); exp_data[1] = 32'h33; cyc(1'b0);
        cyc(1'b1);
        cyc(1'b1);
        cyc(1'b0);

        // Flush with a done head, same-cycle alloc and completion
        alloc_cyc(5'd1, 3'd3, 1'b0);
        alloc_cyc(5'd2, 3'd4, 1'b0);
        alloc_cyc(5'd3, 3'd5, 1'b0);
        alloc_cyc(5'd4, 3'd6, 1'b0);
        cmpl(3'd4, 32'hD4); exp_data[4] = 32'hD4; cyc(1'b0);
        cmpl(3'd3, 32'hD3); exp_data[3] = 32'hD3; cyc(1'b0);
        flush_i       = 1'b1;
        alloc_valid_i = 1'b1;
        alloc_rd_i    = 5'd10;
        cmpl(3'd5, 32'hAA);
        #1;
        chk("flush_wr_en", rf_wr_en_o, 1'b0);
        cyc(1'b0);
        sb.delete();
        #1;
        chk("flush_count", count_o, 4'd0);
        chk("flush_empty", empty_o, 1'b1);
        chk("flush_commit", commit_o, 1'b0);
        alloc_cyc(5'd12, 3'd0, 1'b0);
        cmpl(3'd0, 32'h5A); exp_data[0] = 32'h5A; cyc(1'b0);
        cyc(1'b1);
        cyc(1'b0);
        chk("final_count", count_o, 4'd0);
        chk("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
